// File: rtl/srt_multiple_gen_pkg.sv
// Shared definitions for the SRT divider datapath:
// quotient-digit codes and the multiple-generator state type.
package srt_multiple_gen_pkg;

  localparam logic [2:0] Q_ZERO = 3'b000;
  localparam logic [2:0] Q_P1   = 3'b001;
  localparam logic [2:0] Q_P2   = 3'b010;
  localparam logic [2:0] Q_M1   = 3'b110;
  localparam logic [2:0] Q_M2   = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PREP,
    ST_READY
  } state_t;

endpackage

// File: rtl/srt_digit_mux.sv
// Combinational selection of a precomputed divisor multiple
// by quotient digit; unknown codes yield zero and flag illegal.
module srt_digit_mux
  import srt_multiple_gen_pkg::*;
#(
  parameter int W      = 26,
  parameter int RADIX4 = 1
) (
  input  logic [2:0]   q_i,
  input  logic [W-1:0] mp1_i,
  input  logic [W-1:0] mp2_i,
  input  logic [W-1:0] mm1_i,
  input  logic [W-1:0] mm2_i,
  output logic [W-1:0] qd_o,
  output logic         illegal_o
);

  always_comb begin
    qd_o      = '0;
    illegal_o = 1'b0;
    case (q_i)
      Q_ZERO: qd_o = '0;
      Q_P1:   qd_o = mp1_i;
      Q_M1:   qd_o = mm1_i;
      Q_P2: begin
        if (RADIX4 != 0) qd_o = mp2_i;
        else             illegal_o = 1'b1;
      end
      Q_M2: begin
        if (RADIX4 != 0) qd_o = mm2_i;
        else             illegal_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/srt_multiple_gen.sv
// Divisor-multiple generator: latches d, precomputes +-d/+-2d,
// then streams q*d per accepted digit through a 1-deep output stage.
module srt_multiple_gen
  import srt_multiple_gen_pkg::*;
#(
  parameter int W      = 26,
  parameter int RADIX4 = 1,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_load,
  input  logic [W-1:0]  d_in,
  output logic          load_ready,
  input  logic          in_valid,
  input  logic [2:0]    q,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  qd,
  output logic          illegal,
  output logic [CW-1:0] dig_cnt
);

  state_t        state_q, state_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  mp1_q, mp1_d;
  logic [W-1:0]  mp2_q, mp2_d;
  logic [W-1:0]  mm1_q, mm1_d;
  logic [W-1:0]  mm2_q, mm2_d;
  logic          ov_q, ov_d;
  logic [W-1:0]  qd_q, qd_d;
  logic          ill_q, ill_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  mux_qd;
  logic          mux_ill;
  logic [W-1:0]  d_x2;
  logic          load_acc;
  logic          dig_acc;

  srt_digit_mux #(
    .W      (W),
    .RADIX4 (RADIX4)
  ) u_mux (
    .q_i       (q),
    .mp1_i     (mp1_q),
    .mp2_i     (mp2_q),
    .mm1_i     (mm1_q),
    .mm2_i     (mm2_q),
    .qd_o      (mux_qd),
    .illegal_o (mux_ill)
  );

  // A new divisor may only land once the output stage is empty.
  assign load_ready = (state_q == ST_EMPTY) ||
                      ((state_q == ST_READY) && !ov_q);
  assign load_acc   = d_load && load_ready;
  assign in_ready   = (state_q == ST_READY) && !d_load &&
                      (!ov_q || out_ready);
  assign dig_acc    = in_valid && in_ready;
  assign d_x2       = d_q << 1;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    mp1_d   = mp1_q;
    mp2_d   = mp2_q;
    mm1_d   = mm1_q;
    mm2_d   = mm2_q;
    ov_d    = ov_q;
    qd_d    = qd_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (load_acc) state_d = ST_PREP;
      end
      ST_PREP: begin
        mp1_d   = d_q;
        mp2_d   = d_x2;
        mm1_d   = ~d_q + W'(1);
        mm2_d   = ~d_x2 + W'(1);
        state_d = ST_READY;
      end
      ST_READY: begin
        if (load_acc) state_d = ST_PREP;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load_acc) begin
      d_d   = d_in;
      cnt_d = '0;
    end

    if (dig_acc) begin
      ov_d  = 1'b1;
      qd_d  = mux_qd;
      ill_d = mux_ill;
      if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      d_q     <= '0;
      mp1_q   <= '0;
      mp2_q   <= '0;
      mm1_q   <= '0;
      mm2_q   <= '0;
      ov_q    <= 1'b0;
      qd_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      mp1_q   <= mp1_d;
      mp2_q   <= mp2_d;
      mm1_q   <= mm1_d;
      mm2_q   <= mm2_d;
      ov_q    <= ov_d;
      qd_q    <= qd_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = ov_q;
  assign qd        = qd_q;
  assign illegal   = ill_q;
  assign dig_cnt   = cnt_q;

endmodule
